// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states, ALU
// operation classes, opcode constants and datapath mux encodings.
package core_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the controller and the multicycle datapath/memory. The
// controller takes the slave view; the datapath side takes the master view.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
    logic       illegal;

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca,
               alusrcb, regwrite, immsrc, alucontrol, illegal
    );

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca,
               alusrcb, regwrite, immsrc, alucontrol, illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: maps the FSM's operation class plus the funct fields of
// the current instruction onto the ALU's 3-bit operation select.
module alu_decoder
    import core_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // funct3 000 is sub only for R-type with funct7[5]; addi never subtracts
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if ({op5, funct7b5} == 2'b11) begin
                            alucontrol = ALU_SUB;
                        end else begin
                            alucontrol = ALU_ADD;
                        end
                    end
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences PC/IR enables, memory
// access, ALU operand and result muxes, and register-file writes.
module multicycle_controller
    import core_pkg::*;
#(
    parameter bit HANDSHAKE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.slave   cif
);

    state_e     state_r;
    state_e     next_state_s;
    aluop_e     aluop_s;
    logic       rdy_s;
    logic       pcwrite_s;
    logic       adrsrc_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic [1:0] resultsrc_s;
    logic [1:0] alusrca_s;
    logic [1:0] alusrcb_s;
    logic       regwrite_s;
    logic       illegal_s;
    logic [1:0] immsrc_s;
    logic [2:0] alucontrol_s;

    assign rdy_s = HANDSHAKE ? cif.mem_ready : 1'b1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        next_state_s = state_r;
        aluop_s      = ALUOP_ADD;
        pcwrite_s    = 1'b0;
        adrsrc_s     = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        resultsrc_s  = RES_ALUOUT;
        alusrca_s    = SRCA_PC;
        alusrcb_s    = SRCB_RD2;
        regwrite_s   = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                alusrcb_s    = SRCB_FOUR;
                resultsrc_s  = RES_ALURESULT;
                irwrite_s    = rdy_s;
                pcwrite_s    = rdy_s;
                next_state_s = rdy_s ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target PC+imm is parked in ALUOut for BEQ
                alusrca_s = SRCA_OLDPC;
                alusrcb_s = SRCB_IMM;
                case (cif.op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXECR;
                    OP_ITYPE:     next_state_s = S_EXECI;
                    OP_BEQ:       next_state_s = S_BEQ;
                    OP_JAL:       next_state_s = S_JAL;
                    default: begin
                        next_state_s = S_FETCH;
                        illegal_s    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s = SRCA_RD1;
                alusrcb_s = SRCB_IMM;
                if (cif.op == OP_SW) begin
                    next_state_s = S_MEMWRITE;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adrsrc_s     = 1'b1;
                next_state_s = rdy_s ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWRITE: begin
                adrsrc_s     = 1'b1;
                memwrite_s   = 1'b1;
                next_state_s = rdy_s ? S_FETCH : S_MEMWRITE;
            end
            S_MEMWB: begin
                resultsrc_s  = RES_DATA;
                regwrite_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_EXECR: begin
                alusrca_s    = SRCA_RD1;
                aluop_s      = ALUOP_FUNCT;
                next_state_s = S_ALUWB;
            end
            S_EXECI: begin
                alusrca_s    = SRCA_RD1;
                alusrcb_s    = SRCB_IMM;
                aluop_s      = ALUOP_FUNCT;
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BEQ: begin
                alusrca_s    = SRCA_RD1;
                aluop_s      = ALUOP_SUB;
                pcwrite_s    = cif.zero;
                next_state_s = S_FETCH;
            end
            S_JAL: begin
                // OldPC+4 becomes the link value written in ALUWB
                alusrca_s    = SRCA_OLDPC;
                alusrcb_s    = SRCB_FOUR;
                pcwrite_s    = 1'b1;
                next_state_s = S_ALUWB;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // Immediate format select, straight from the opcode
    always_comb begin
        immsrc_s = IMM_I;
        case (cif.op)
            OP_LW, OP_ITYPE: immsrc_s = IMM_I;
            OP_SW:           immsrc_s = IMM_S;
            OP_BEQ:          immsrc_s = IMM_B;
            OP_JAL:          immsrc_s = IMM_J;
            default:         immsrc_s = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop_s),
        .funct3     (cif.funct3),
        .op5        (cif.op[5]),
        .funct7b5   (cif.funct7b5),
        .alucontrol (alucontrol_s)
    );

    // Write enables are forced low while reset is held so no access leaks out
    assign cif.pcwrite    = pcwrite_s  & ~reset;
    assign cif.irwrite    = irwrite_s  & ~reset;
    assign cif.memwrite   = memwrite_s & ~reset;
    assign cif.regwrite   = regwrite_s & ~reset;
    assign cif.illegal    = illegal_s  & ~reset;
    assign cif.adrsrc     = adrsrc_s;
    assign cif.resultsrc  = resultsrc_s;
    assign cif.alusrca    = alusrca_s;
    assign cif.alusrcb    = alusrcb_s;
    assign cif.immsrc     = immsrc_s;
    assign cif.alucontrol = alucontrol_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and compares the full control word every cycle.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    multicycle_controller_if cif ();

    multicycle_controller #(.HANDSHAKE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {cif.pcwrite, cif.adrsrc, cif.memwrite, cif.irwrite,
                  cif.resultsrc, cif.alusrca, cif.alusrcb, cif.regwrite,
                  cif.immsrc, cif.alucontrol, cif.illegal};

    function automatic logic [16:0] ev(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic rw,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill};
    endfunction

    function automatic logic [16:0] fe(input logic [1:0] imm);
        return ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, imm, 3'b000, 1'b0);
    endfunction

    function automatic logic [16:0] de(input logic [1:0] imm);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, imm, 3'b000, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] exp);
        #1;
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        cif.op = 7'b0000011;
        cif.funct3 = 3'b010;
        cif.funct7b5 = 1'b0;
        cif.zero = 1'b0;
        cif.mem_ready = 1'b1;
        chk("reset", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0));
        @(negedge clk);
        reset = 1'b0;

        // lw with memory always ready
        chk("lw_fetch", fe(2'b00));
        tick(); chk("lw_decode", de(2'b00));
        tick(); chk("lw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0));
        tick(); chk("lw_memread", ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0));
        tick(); chk("lw_memwb", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0));
        tick();
        cif.op = 7'b0100011;
        chk("sw_fetch", fe(2'b01));

        // sw with three wait cycles in MEMWRITE
        tick(); chk("sw_decode", de(2'b01));
        tick(); chk("sw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000, 1'b0));
        cif.mem_ready = 1'b0;
        tick(); chk("sw_memwrite1", ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));
        tick(); chk("sw_memwrite2", ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));
        tick(); chk("sw_memwrite3", ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));
        tick();
        cif.mem_ready = 1'b1;
        chk("sw_memwrite4", ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));
        tick(); chk("sw_back_fetch", fe(2'b01));

        // fetch stall, then beq taken and not taken
        cif.op = 7'b1100011;
        cif.zero = 1'b1;
        cif.mem_ready = 1'b0;
        chk("fetch_stall1", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 3'b000, 1'b0));
        tick(); chk("fetch_stall2", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 3'b000, 1'b0));
        cif.mem_ready = 1'b1;
        chk("beq_fetch", fe(2'b10));
        tick(); chk("beq_decode", de(2'b10));
        tick(); chk("beq_taken", ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 1'b0));
        cif.zero = 1'b0;
        chk("beq_not_taken", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 1'b0));
        tick(); chk("beq_back_fetch", fe(2'b10));

        // R-type sub
        cif.op = 7'b0110011;
        cif.funct3 = 3'b000;
        cif.funct7b5 = 1'b1;
        tick(); chk("sub_decode", de(2'b00));
        tick(); chk("sub_execr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0));
        tick(); chk("sub_aluwb", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0));
        tick();
        cif.op = 7'b0010011;
        chk("addi_fetch", fe(2'b00));

        // addi with funct7b5 set must still add; then other funct3 decodes
        tick(); chk("addi_decode", de(2'b00));
        tick(); chk("addi_execi", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0));
        cif.funct3 = 3'b010;
        chk("slti_execi", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b101, 1'b0));
        cif.funct3 = 3'b111;
        chk("andi_execi", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b010, 1'b0));
        cif.funct3 = 3'b110;
        chk("ori_execi", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b011, 1'b0));
        tick(); chk("addi_aluwb", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0));
        tick();
        cif.op = 7'b1101111;
        chk("jal_fetch", fe(2'b11));

        // jal
        tick(); chk("jal_decode", de(2'b11));
        tick(); chk("jal_jal", ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b11, 3'b000, 1'b0));
        tick(); chk("jal_aluwb", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 3'b000, 1'b0));
        tick();
        cif.op = 7'b1110011;
        chk("ill_fetch", fe(2'b00));

        // unsupported opcode
        tick(); chk("ill_decode", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 1'b1));
        tick(); chk("ill_back_fetch", fe(2'b00));

        // reset while stalled in MEMWRITE
        cif.op = 7'b0100011;
        tick(); chk("rst_sw_decode", de(2'b01));
        tick(); chk("rst_sw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000, 1'b0));
        cif.mem_ready = 1'b0;
        tick(); chk("rst_sw_memwrite", ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0));
        reset = 1'b1;
        chk("rst_mid_mw", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0));
        cif.mem_ready = 1'b1;
        tick(); chk("rst_held", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0));
        reset = 1'b0;
        chk("rst_release", fe(2'b01));
        tick(); chk("rst_post_decode", de(2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
